csa_accum_adder: RTL
====================

# csa_accum_adder

Multi-operand integer accumulator for the multiplier and ALU datapath. It takes a stream of WIDTH-bit operands over a valid/ready handshake and keeps the running total in carry-save form, so each beat costs one 3:2 compression level. After the operand flagged last, a chunked, multi-cycle carry-propagate pass resolves the total, CHUNK bits per cycle. It generalises the single-cycle 3:2 compressor and ripple CPA pair to arbitrary width and operand count, with handshaking and a bounded per-cycle carry chain.

## Interface
- WIDTH, 64: operand and result width in bits; must be ≥ 2.
- CHUNK, 16: CPA bits resolved per cycle; must divide WIDTH. NCH = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  operand, unsigned or two's complement (modular sum).
- in_last  input  1  the accepted beat is the final operand of the sum.
- in_sub  input  1  subtract in_data instead of adding it. Present only when ADDERS_SUB_EN is defined.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  WIDTH  resolved sum, modulo 2^WIDTH.

## Operation
- State registers:
  - S and C, both WIDTH bits.
  - FSM state: ACCUM, RESOLVE or DONE.
  - Chunk index k, log2(NCH) bits (min 1).
  - Chunk carry flop cy.
  - Result register R, WIDTH bits.
- Reset (asserting edge of rst_n, asynchronous): state = ACCUM, S = C = 0, k = 0, cy = 0, R = 0. Consequently in_ready = 1, out_valid = 0 and out_sum = 0.
- ACCUM:
  - in_ready = 1.
  - On in_valid, with operand d = in_data:
    - S ← S ^ C ^ d
    - C ← {maj(S,C,d)[WIDTH-2:0], 0}
    - The majority carry out of bit WIDTH-1 is discarded (modular).
  - If in_last is also high, go to RESOLVE with k = 0 and cy = 0.
- RESOLVE:
  - in_ready = 0.
  - Each cycle, {cy, R[k*CHUNK +: CHUNK]} ← S[chunk k] + C[chunk k] + cy, then k++.
  - After chunk NCH-1, go to DONE. The final cy is discarded.
- DONE:
  - out_valid = 1 and out_sum = R.
  - R holds stable while out_ready = 0.
  - On out_ready: S = C = 0, go to ACCUM.
- out_sum equals R in every state; it changes only during RESOLVE.
- Sum of the beats of one operation ≡ out_sum (mod 2^WIDTH). A single-beat operation returns in_data unchanged.
- Operand count per operation is unbounded; overflow wraps silently.
- in_ready and out_valid are never high together. in_ready depends only on state, with no combinational path from out_ready.

## Timing
- Beat throughput: one per cycle in ACCUM.
- Last beat accepted at edge t:
  - RESOLVE occupies edges t+1 … t+NCH.
  - out_valid rises after edge t+NCH, so the result is visible in cycle t+NCH.
- out_ready sampled high in DONE at edge u: in_ready is 1 in cycle u+1, so the next beat can be accepted at edge u+1.
- in_valid, in_data, in_last and in_sub are ignored outside ACCUM.
- rst_n asserted in any state, including mid-RESOLVE or DONE: the partial sum is discarded and the reset values apply immediately. First acceptance is possible at the first rising edge after rst_n deasserts.

## Configuration
- ADDERS_SUB_EN defined:
  - in_sub port exists.
  - A beat with in_sub = 1 compresses d = ~in_data and forces the new C[0] = 1. C[0] is always 0 from the shift, so this injects +1 and yields two's-complement subtraction with no extra adder.
- ADDERS_SUB_EN undefined:
  - in_sub port is absent.
  - C[0] is always 0.
  - All beats add.

## Test plan
- WIDTH=64, CHUNK=16. Single beat 0x0123_4567_89AB_CDEF with last → out_sum = 0x0123_4567_89AB_CDEF, out_valid 4 cycles after acceptance.
- Beats 0xFFFF_FFFF_FFFF_FFFF, 1, 1 (last) → out_sum = 1, wrapped. Carry ripples across all chunk boundaries.
- 100 back-to-back beats of value i (0..99), out_ready held 0 for 5 cycles in DONE → out_sum = 4950 (0x1356), stable throughout, in_ready = 0 until the handshake.
- ADDERS_SUB_EN: beats 10, then 25 with in_sub = 1 (last) → out_sum = 0xFFFF_FFFF_FFFF_FFF1 (−15).
- rst_n pulsed low in the second RESOLVE cycle → out_valid = 0 and out_sum = 0 immediately. A subsequent single beat 7 (last) yields 7.
- WIDTH=32, CHUNK=8, random beat streams with random in_valid and out_ready stalls → out_sum matches the reference model mod 2^32, latency exactly 4 cycles, no beats lost or duplicated.

Source files
------------

// File: rtl/csa_accum_adder.sv
// csa_accum_adder: multi-operand accumulator. Operands are folded into a
// carry-save pair (S, C) at one 3:2 level per beat; after the last beat a
// chunked ripple pass resolves S + C into R, CHUNK bits per cycle.
// Optional feature macro: ADDERS_SUB_EN (adds in_sub_i, per-beat subtract).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_ACCUM   | accepting operand beats, compressing into S/C
// ST_RESOLVE | propagating carries through S + C, one chunk per cycle
// ST_DONE    | result valid in R, waiting for the consumer handshake
module csa_accum_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
`ifdef ADDERS_SUB_EN
  input  logic             in_sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] s_q, c_q, r_q;
  logic [WIDTH-1:0] s_d, c_d;
  logic [KW-1:0]    k_q;
  logic             cy_q;
  logic             in_ready_q, out_valid_q;
  logic             sub_w;
  logic [WIDTH-1:0] opnd_w;
  logic [WIDTH-2:0] maj_lo;
  logic [CHUNK-1:0] s_ch, c_ch;
  logic [CHUNK:0]   chunk_sum;

`ifdef ADDERS_SUB_EN
  assign sub_w = in_sub_i;
`else
  assign sub_w = 1'b0;
`endif

  // 3:2 compression of the incoming operand into the carry-save pair.
  // Subtraction feeds ~d and injects the +1 through the always-empty C[0].
  always_comb begin
    opnd_w = sub_w ? ~in_data_i : in_data_i;
    s_d    = s_q ^ c_q ^ opnd_w;
    maj_lo = (s_q[WIDTH-2:0] & c_q[WIDTH-2:0]) |
             (s_q[WIDTH-2:0] & opnd_w[WIDTH-2:0]) |
             (c_q[WIDTH-2:0] & opnd_w[WIDTH-2:0]);
    c_d    = {maj_lo, sub_w};
  end

  // Carry-propagate add of the current chunk, carry-in from the previous one.
  always_comb begin
    s_ch      = s_q[k_q*CHUNK +: CHUNK];
    c_ch      = c_q[k_q*CHUNK +: CHUNK];
    chunk_sum = {1'b0, s_ch} + {1'b0, c_ch} + {{CHUNK{1'b0}}, cy_q};
  end

  // Sequencing FSM with registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      cy_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid_i) begin
            s_q <= s_d;
            c_q <= c_d;
            if (in_last_i) begin
              state_q    <= ST_RESOLVE;
              k_q        <= '0;
              cy_q       <= 1'b0;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          r_q[k_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          cy_q                    <= chunk_sum[CHUNK];
          if (k_q == K_LAST) begin
            state_q     <= ST_DONE;
            k_q         <= '0;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            s_q         <= '0;
            c_q         <= '0;
            state_q     <= ST_ACCUM;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_sum_o   = r_q;

endmodule
